// File: rtl/cam_pkg.sv
// Shared camera-path types and constants for the frame capture sequencer.
package cam_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        CAPTURE,
        DONE
    } capture_state_t;

    localparam int unsigned CAM_LINES  = 480;
    localparam int unsigned CAM_COLS   = 640;
    localparam int unsigned LINE_CNT_W = 10;

    // Saturating increment for the per-frame line counter.
    function automatic logic [LINE_CNT_W-1:0] sat_inc(input logic [LINE_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/frame_capture_ctrl_sig_edge.sv
// sig_edge: 1-bit registered edge detector; rise/fall compare the input against
// its value on the previous clock.
module sig_edge (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) d_q <= 1'b0;
        else     d_q <= d_i;
    end

    assign rise_o = ~d_q & d_i;
    assign fall_o = d_q & ~d_i;

endmodule

// File: rtl/frame_capture_ctrl.sv
// Frame capture sequencer: gates frame-buffer writes per frame in snapshot or
// continuous mode with frame skipping. Optional line-count check: FRAME_CHECK_EN.
module frame_capture_ctrl
    import cam_pkg::*;
#(
    parameter int unsigned LINES_PER_FRAME = CAM_LINES,
    parameter int unsigned SKIP_W          = 4,
    parameter int unsigned CNT_W           = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              config_done,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic              run_en,
    input  logic              snap_req,
    input  logic [SKIP_W-1:0] skip_frames,
    output logic              capture_en,
    output logic              busy,
    output logic              frame_done,
    output logic [CNT_W-1:0]  frame_count,
    output logic [9:0]        line_count,
    output logic              frame_err
);

    capture_state_t        state_q, state_d;
    logic [SKIP_W-1:0]     skip_cnt_q, skip_cnt_d;
    logic                  snap_pending_q, snap_pending_d;
    logic                  capture_en_q, busy_q, frame_done_q;
    logic [CNT_W-1:0]      frame_count_q, frame_count_d;
    logic [LINE_CNT_W-1:0] line_count_q, line_count_d;
    logic                  vs_rise, vs_fall, hr_rise, hr_fall;
    logic                  enter_capture, enter_done, want_frame;

    sig_edge u_vs_edge (
        .clk    (clk),
        .rst    (reset),
        .d_i    (cam_vsync),
        .rise_o (vs_rise),
        .fall_o (vs_fall)
    );

    sig_edge u_hr_edge (
        .clk    (clk),
        .rst    (reset),
        .d_i    (cam_href),
        .rise_o (hr_rise),
        .fall_o (hr_fall)
    );

    assign want_frame = run_en | snap_pending_q | snap_req;

    always_comb begin
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        if (!config_done) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (want_frame) begin
                        state_d    = ARM;
                        skip_cnt_d = skip_frames;
                    end
                end
                ARM: begin
                    if (!want_frame) begin
                        state_d = IDLE;
                    end else if (vs_fall) begin
                        if (skip_cnt_q == '0) state_d = CAPTURE;
                        else                  skip_cnt_d = skip_cnt_q - 1'b1;
                    end
                end
                CAPTURE: begin
                    if (vs_rise) state_d = DONE;
                end
                DONE: begin
                    if (want_frame) begin
                        state_d    = ARM;
                        skip_cnt_d = skip_frames;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign enter_capture = (state_q == ARM) && (state_d == CAPTURE);
    assign enter_done    = (state_q == CAPTURE) && (state_d == DONE);

    always_comb begin
        snap_pending_d = snap_req | (snap_pending_q & ~enter_capture);
        frame_count_d  = enter_done ? frame_count_q + 1'b1 : frame_count_q;
        line_count_d   = line_count_q;
        if (enter_capture)
            line_count_d = '0;
        else if ((state_q == CAPTURE) && hr_fall)
            line_count_d = sat_inc(line_count_q);
    end

    // Outputs are registered from the next state so they align with the state edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            skip_cnt_q     <= '0;
            snap_pending_q <= 1'b0;
            capture_en_q   <= 1'b0;
            busy_q         <= 1'b0;
            frame_done_q   <= 1'b0;
            frame_count_q  <= '0;
            line_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            skip_cnt_q     <= skip_cnt_d;
            snap_pending_q <= snap_pending_d;
            capture_en_q   <= (state_d == CAPTURE);
            busy_q         <= (state_d != IDLE);
            frame_done_q   <= (state_d == DONE);
            frame_count_q  <= frame_count_d;
            line_count_q   <= line_count_d;
        end
    end

    assign capture_en  = capture_en_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    assign line_count  = line_count_q;

`ifdef FRAME_CHECK_EN
    localparam logic [LINE_CNT_W-1:0] LINES_EXP = LINE_CNT_W'(LINES_PER_FRAME);
    logic frame_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            frame_err_q <= 1'b0;
        else if (enter_done && (line_count_q != LINES_EXP))
            frame_err_q <= 1'b1;
    end

    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

endmodule
